// File: rtl/fft_pkg.sv
// Shared constants, unload FSM state type and address bit-reversal helper
// for the FFT butterfly write-back path.
package fft_pkg;

  localparam int unsigned BIT_DEF  = 17;
  localparam int unsigned ADDR_DEF = 10;
  localparam int unsigned LEGS     = 4;
  localparam int unsigned LEG_W    = $clog2(LEGS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } unload_state_e;

  // Reverses the low w bits of a; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] a, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[i[4:0]] = a[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_but_slot_buf.sv
// Two-entry ping-pong buffer holding butterfly result sets until the
// write-back FSM has streamed them out.
module fft_but_slot_buf #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid,
  input  logic [PW-1:0] push_data,
  input  logic          pop,
  output logic [PW-1:0] rd_data,
  output logic          rd_full,
  output logic          oth_full,
  output logic          ready,
  output logic          any_full
);

  logic [PW-1:0] slot_q [2];
  logic [PW-1:0] slot_d [2];
  logic [1:0]    full_q, full_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          accept;

  assign ready    = !(full_q[0] && full_q[1]);
  assign accept   = valid && ready;
  assign rd_data  = slot_q[rd_ptr_q];
  assign rd_full  = full_q[rd_ptr_q];
  assign oth_full = full_q[~rd_ptr_q];
  assign any_full = |full_q;

  // Capture and release always target different slots, so both may fire together.
  always_comb begin
    slot_d   = slot_q;
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      slot_d[wr_ptr_q] = push_data;
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q   <= '{default: '0};
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/fft_but_unload.sv
// Butterfly write-back: serializes buffered result sets to the FFT RAM with
// strided addressing. Define FFT_UNLOAD_BITREV_EN to add the iBITREV reorder.
module fft_but_unload
  import fft_pkg::*;
#(
  parameter int unsigned BIT  = BIT_DEF,
  parameter int unsigned ADDR = ADDR_DEF
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic                  iVALID,
  output logic                  oREADY,
  input  logic                  iBUT_SEL,
  input  logic [ADDR-1:0]       iBASE_ADDR,
  input  logic [ADDR-1:0]       iSTRIDE,
`ifdef FFT_UNLOAD_BITREV_EN
  input  logic                  iBITREV,
`endif
  input  logic signed [BIT-1:0] iY0_RE,
  input  logic signed [BIT-1:0] iY0_IM,
  input  logic signed [BIT-1:0] iY1_RE,
  input  logic signed [BIT-1:0] iY1_IM,
  input  logic signed [BIT-1:0] iY2_RE,
  input  logic signed [BIT-1:0] iY2_IM,
  input  logic signed [BIT-1:0] iY3_RE,
  input  logic signed [BIT-1:0] iY3_IM,
  output logic                  oWR_EN,
  output logic [ADDR-1:0]       oWR_ADDR,
  output logic signed [BIT-1:0] oWR_RE,
  output logic signed [BIT-1:0] oWR_IM,
  output logic                  oBUSY,
  output logic                  oERR
);

  typedef struct packed {
`ifdef FFT_UNLOAD_BITREV_EN
    logic                     bitrev;
`endif
    logic                     but_sel;
    logic [ADDR-1:0]          base;
    logic [ADDR-1:0]          stride;
    logic [LEGS-1:0][BIT-1:0] re;
    logic [LEGS-1:0][BIT-1:0] im;
  } slot_t;

  slot_t                  push_slot, cur_slot;
  logic                   rd_full, oth_full, any_full, ready, pop;
  unload_state_e          state_q, state_d;
  logic [LEG_W-1:0]       leg_q, leg_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR-1:0]        wr_addr_q, wr_addr_d;
  logic signed [BIT-1:0]  wr_re_q, wr_re_d, wr_im_q, wr_im_d;
  logic                   err_q, err_d;
  logic                   emit;
  logic [ADDR-1:0]        offset, addr_raw, addr_fin;

  always_comb begin
    push_slot         = '0;
`ifdef FFT_UNLOAD_BITREV_EN
    push_slot.bitrev  = iBITREV;
`endif
    push_slot.but_sel = iBUT_SEL;
    push_slot.base    = iBASE_ADDR;
    push_slot.stride  = iSTRIDE;
    push_slot.re      = {iY3_RE, iY2_RE, iY1_RE, iY0_RE};
    push_slot.im      = {iY3_IM, iY2_IM, iY1_IM, iY0_IM};
  end

  fft_but_slot_buf #(.PW($bits(slot_t))) u_slot_buf (
    .clk      (iCLK),
    .rst_n    (iRESET),
    .valid    (iVALID),
    .push_data(push_slot),
    .pop      (pop),
    .rd_data  (cur_slot),
    .rd_full  (rd_full),
    .oth_full (oth_full),
    .ready    (ready),
    .any_full (any_full)
  );

  // 2-dot mode pairs legs as (base, base+stride) and (base+1, base+1+stride).
  always_comb begin
    offset = '0;
    if (cur_slot.but_sel) begin
      case (leg_q)
        2'd0:    offset = '0;
        2'd1:    offset = cur_slot.stride;
        2'd2:    offset = ADDR'(1);
        default: offset = cur_slot.stride + ADDR'(1);
      endcase
    end else begin
      case (leg_q)
        2'd0:    offset = '0;
        2'd1:    offset = cur_slot.stride;
        2'd2:    offset = cur_slot.stride << 1;
        default: offset = (cur_slot.stride << 1) + cur_slot.stride;
      endcase
    end
    addr_raw = cur_slot.base + offset;
`ifdef FFT_UNLOAD_BITREV_EN
    addr_fin = cur_slot.bitrev ? ADDR'(bitrev(32'(addr_raw), ADDR)) : addr_raw;
`else
    addr_fin = addr_raw;
`endif
  end

  always_comb begin
    state_d   = state_q;
    leg_d     = leg_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_re_d   = wr_re_q;
    wr_im_d   = wr_im_q;
    pop       = 1'b0;
    emit      = 1'b0;
    err_d     = err_q | (iVALID & ~ready);
    case (state_q)
      ST_IDLE:  emit = rd_full;
      ST_DRAIN: emit = 1'b1;
      default:  emit = 1'b0;
    endcase
    if (emit) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_fin;
      wr_re_d   = cur_slot.re[leg_q];
      wr_im_d   = cur_slot.im[leg_q];
      if (leg_q == LEG_W'(LEGS - 1)) begin
        pop     = 1'b1;
        leg_d   = '0;
        state_d = oth_full ? ST_DRAIN : ST_IDLE;
      end else begin
        leg_d   = leg_q + 1'b1;
        state_d = ST_DRAIN;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state_q   <= ST_IDLE;
      leg_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_re_q   <= '0;
      wr_im_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      leg_q     <= leg_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_re_q   <= wr_re_d;
      wr_im_q   <= wr_im_d;
      err_q     <= err_d;
    end
  end

  assign oREADY   = ready;
  assign oWR_EN   = wr_en_q;
  assign oWR_ADDR = wr_addr_q;
  assign oWR_RE   = wr_re_q;
  assign oWR_IM   = wr_im_q;
  assign oBUSY    = any_full | wr_en_q;
  assign oERR     = err_q;

endmodule

// File: tb/tb_fft_but_unload.sv
// Self-checking bench for fft_but_unload: directed address/timing scenarios
// plus randomized transfers checked against a queue-based write model.
module tb_fft_but_unload;

  localparam int BIT  = 17;
  localparam int ADDR = 10;
  localparam int N    = 1 << ADDR;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  valid = 1'b0;
  logic                  but_sel = 1'b0;
  logic [ADDR-1:0]       base = '0;
  logic [ADDR-1:0]       stride = '0;
  logic signed [BIT-1:0] y [8] = '{default: '0};
`ifdef FFT_UNLOAD_BITREV_EN
  logic                  brev = 1'b0;
`endif
  logic                  ready, wr_en, busy, err;
  logic [ADDR-1:0]       wr_addr;
  logic signed [BIT-1:0] wr_re, wr_im;

  typedef struct {
    int cyc;
    int addr;
    int re;
    int im;
  } wr_t;

  wr_t cap_q[$];
  wr_t exp_q[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  int tbl_base [3] = '{'h010, 'h020, 'h3F0};
  int tbl_str  [3] = '{'h040, 'h001, 'h100};
  int tbl_sel  [3] = '{0, 1, 0};
  int tbl_adr  [3][4] = '{'{'h010, 'h050, 'h090, 'h0D0},
                          '{'h020, 'h021, 'h021, 'h022},
                          '{'h3F0, 'h0F0, 'h1F0, 'h2F0}};

  fft_but_unload #(.BIT(BIT), .ADDR(ADDR)) dut (
    .iCLK      (clk),
    .iRESET    (rst_n),
    .iVALID    (valid),
    .oREADY    (ready),
    .iBUT_SEL  (but_sel),
    .iBASE_ADDR(base),
    .iSTRIDE   (stride),
`ifdef FFT_UNLOAD_BITREV_EN
    .iBITREV   (brev),
`endif
    .iY0_RE    (y[0]),
    .iY0_IM    (y[1]),
    .iY1_RE    (y[2]),
    .iY1_IM    (y[3]),
    .iY2_RE    (y[4]),
    .iY2_IM    (y[5]),
    .iY3_RE    (y[6]),
    .iY3_IM    (y[7]),
    .oWR_EN    (wr_en),
    .oWR_ADDR  (wr_addr),
    .oWR_RE    (wr_re),
    .oWR_IM    (wr_im),
    .oBUSY     (busy),
    .oERR      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_en === 1'b1) cap_q.push_back('{cyc, int'(wr_addr), int'(wr_re), int'(wr_im)});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int ref_addr(int b, int s, int sel, int k, int br);
    int a, r;
    a = (sel != 0) ? b + (k % 2) * s + k / 2 : b + k * s;
    a = a % N;
    if (br != 0) begin
      r = 0;
      for (int i = 0; i < ADDR; i++) if (a[i]) r = r | (1 << (ADDR - 1 - i));
      a = r;
    end
    return a;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < 8; i++) y[i] = BIT'($urandom);
  endtask

  // Called at a negedge; drives one iVALID cycle and returns at the following negedge.
  task automatic send(input int b, input int s, input int sel, input int br, output bit acc, output int tc);
    base    = ADDR'(b);
    stride  = ADDR'(s);
    but_sel = sel[0];
`ifdef FFT_UNLOAD_BITREV_EN
    brev    = br[0];
`endif
    acc   = ready;
    valid = 1'b1;
    if (acc) for (int k = 0; k < 4; k++)
      exp_q.push_back('{0, ref_addr(b, s, sel, k, br), int'(y[2*k]), int'(y[2*k+1])});
    @(negedge clk);
    valid = 1'b0;
    tc    = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    rand_data();
    base = ADDR'($urandom);
    repeat (3) @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
    total++; if (wr_addr !== '0) begin bad++; $display("FAIL reset_wr_addr got=%h want=0", wr_addr); end
    total++; if (wr_re !== '0 || wr_im !== '0) begin bad++; $display("FAIL reset_wr_data got=%h/%h want=0/0", wr_re, wr_im); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
  endtask

  task automatic test_addr_modes();
    bit acc;
    int tc, idle_c;
    for (int r = 0; r < 3; r++) begin
      cap_q.delete();
      exp_q.delete();
      rand_data();
      if (r == 0) begin y[0] = 1; y[2] = 2; y[4] = 3; y[6] = 4; end
      send(tbl_base[r], tbl_str[r], tbl_sel[r], 0, acc, tc);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL mode%0d_accept got=%b want=1", r, acc); end
      idle_c = -1;
      for (int i = 0; i < 50; i++) begin
        if (!busy) begin idle_c = cyc; break; end
        @(negedge clk);
      end
      total++; if (idle_c != tc + 5) begin bad++; $display("FAIL mode%0d_busy_drop got=%0d want=%0d", r, idle_c, tc + 5); end
      total++; if (cap_q.size() != 4) begin bad++; $display("FAIL mode%0d_count got=%0d want=4", r, cap_q.size()); end
      for (int k = 0; k < cap_q.size() && k < 4; k++) begin
        total++;
        if (cap_q[k].addr != tbl_adr[r][k] || cap_q[k].re != int'(y[2*k]) || cap_q[k].im != int'(y[2*k+1])
            || cap_q[k].cyc != tc + 1 + k) begin
          bad++;
          $display("FAIL mode%0d_leg%0d got addr=%h re=%0d im=%0d cyc=%0d want addr=%h re=%0d im=%0d cyc=%0d",
                   r, k, cap_q[k].addr, cap_q[k].re, cap_q[k].im, cap_q[k].cyc,
                   tbl_adr[r][k], int'(y[2*k]), int'(y[2*k+1]), tc + 1 + k);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit acc [3];
    int tc, t1, rc, idle_c;
    cap_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      rand_data();
      send($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, 1), 0, acc[i], tc);
      if (i == 0) t1 = tc;
    end
    total++; if (acc[0] !== 1'b1 || acc[1] !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b%b want=11", acc[0], acc[1]); end
    total++; if (acc[2] !== 1'b0) begin bad++; $display("FAIL b2b_third_ready got=%b want=0", acc[2]); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL b2b_err got=%b want=1", err); end
    rc = -1;
    for (int i = 0; i < 10; i++) begin
      if (ready) begin rc = cyc; break; end
      @(negedge clk);
    end
    total++; if (rc != t1 + 4) begin bad++; $display("FAIL b2b_ready_return got=%0d want=%0d", rc, t1 + 4); end
    idle_c = -1;
    for (int i = 0; i < 50; i++) begin
      if (!busy) begin idle_c = cyc; break; end
      @(negedge clk);
    end
    total++; if (idle_c != t1 + 9) begin bad++; $display("FAIL b2b_idle got=%0d want=%0d", idle_c, t1 + 9); end
    total++; if (cap_q.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (cap_q[i].addr != exp_q[i].addr || cap_q[i].re != exp_q[i].re || cap_q[i].im != exp_q[i].im
          || cap_q[i].cyc != t1 + 1 + i) begin
        bad++;
        $display("FAIL b2b_write%0d got addr=%h re=%0d im=%0d cyc=%0d want addr=%h re=%0d im=%0d cyc=%0d",
                 i, cap_q[i].addr, cap_q[i].re, cap_q[i].im, cap_q[i].cyc,
                 exp_q[i].addr, exp_q[i].re, exp_q[i].im, t1 + 1 + i);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    bit acc;
    int ta, tb;
    cap_q.delete();
    exp_q.delete();
    rand_data();
    send($urandom_range(0, N - 1), $urandom_range(1, N - 1), 0, 0, acc, ta);
    rand_data();
    send($urandom_range(0, N - 1), $urandom_range(1, N - 1), 1, 0, acc, tb);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rstmid_wr_en got=%b want=0", wr_en); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b want=0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (cap_q.size() != 2) begin bad++; $display("FAIL rstmid_writes got=%0d want=2", cap_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=%b want=0", busy); end
  endtask

  task automatic test_random();
    bit acc;
    int tc, w, br, idle_c;
    cap_q.delete();
    exp_q.delete();
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      w = 0;
      while (!ready && w < 20) begin @(negedge clk); w++; end
      rand_data();
`ifdef FFT_UNLOAD_BITREV_EN
      br = $urandom_range(0, 1);
`else
      br = 0;
`endif
      send($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, 1), br, acc, tc);
    end
    idle_c = -1;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin idle_c = cyc; break; end
      @(negedge clk);
    end
    total++; if (idle_c < 0) begin bad++; $display("FAIL rand_drain_timeout got=busy want=idle"); end
    total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (cap_q[i].addr != exp_q[i].addr || cap_q[i].re != exp_q[i].re || cap_q[i].im != exp_q[i].im) begin
        bad++;
        $display("FAIL rand_write%0d got addr=%h re=%0d im=%0d want addr=%h re=%0d im=%0d",
                 i, cap_q[i].addr, cap_q[i].re, cap_q[i].im, exp_q[i].addr, exp_q[i].re, exp_q[i].im);
      end
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rand_err got=%b want=0", err); end
  endtask

`ifdef FFT_UNLOAD_BITREV_EN
  task automatic test_bitrev();
    bit acc;
    int tc;
    int want [4] = '{'h200, 'h300, 'h280, 'h380};
    cap_q.delete();
    exp_q.delete();
    rand_data();
    send('h001, 'h002, 0, 1, acc, tc);
    repeat (8) @(negedge clk);
    total++; if (cap_q.size() != 4) begin bad++; $display("FAIL bitrev_count got=%0d want=4", cap_q.size()); end
    for (int k = 0; k < cap_q.size() && k < 4; k++) begin
      total++;
      if (cap_q[k].addr != want[k]) begin
        bad++;
        $display("FAIL bitrev_leg%0d got addr=%h want=%h", k, cap_q[k].addr, want[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_addr_modes();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
`ifdef FFT_UNLOAD_BITREV_EN
    test_bitrev();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
